// File: rtl/cmem_pingpong_if.sv
// Port bundle for the double-buffered FIR coefficient memory: load, swap and read buses.
// The master drives requests and addresses; the slave (memory) returns status and read data.
interface cmem_pingpong_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int NPORT  = 8
) ();
  logic                     CEN;
  logic                     WEN;
  logic [DATA_W-1:0]        D;
  logic                     ld_start;
  logic [ADDR_W-1:0]        ld_last;
  logic                     ld_busy;
  logic                     ld_done;
  logic                     swap_req;
  logic                     swap_ack;
  logic                     active_bank;
  logic [NPORT*ADDR_W-1:0]  A;
  logic [NPORT*DATA_W-1:0]  Q;

  modport master (
    output CEN, WEN, D, ld_start, ld_last, swap_req, A,
    input  ld_busy, ld_done, swap_ack, active_bank, Q
  );

  modport slave (
    input  CEN, WEN, D, ld_start, ld_last, swap_req, A,
    output ld_busy, ld_done, swap_ack, active_bank, Q
  );
endinterface

// File: rtl/cmem_pingpong.sv
// Ping-pong coefficient memory: NPORT registered readers on the active bank, a sequential
// load engine on the shadow bank, and a swap that only lands on a completed load.
module cmem_pingpong #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int NPORT  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  cmem_pingpong_if.slave   bus
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t                  state;
  logic [ADDR_W-1:0]       wptr;
  logic [ADDR_W-1:0]       last;
  logic                    active;
  logic                    pending;
  logic                    busy_r;
  logic                    done_r;
  logic                    ack_r;
  logic [NPORT*DATA_W-1:0] q_r;
  logic [DATA_W-1:0]       mem [2][DEPTH];

  logic wr_en;
  logic load_end;
  logic swap_go;

  // The final write and the swap may share an edge: the bank is complete once that edge lands.
  assign wr_en    = rst_n && (state == LOAD) && !bus.CEN && !bus.WEN;
  assign load_end = wr_en && (wptr == last);
  assign swap_go  = ((state != LOAD) || load_end) && (pending || bus.swap_req);

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      wptr    <= '0;
      last    <= '0;
      active  <= 1'b0;
      pending <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      ack_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      ack_r  <= swap_go;

      if (swap_go) begin
        active  <= ~active;
        pending <= 1'b0;
      end else if (bus.swap_req) begin
        pending <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (bus.ld_start) begin
            state  <= LOAD;
            wptr   <= '0;
            last   <= bus.ld_last;
            busy_r <= 1'b1;
          end
        end
        LOAD: begin
          if (wr_en) begin
            wptr <= wptr + 1'b1;
            if (wptr == last) begin
              state  <= DONE;
              busy_r <= 1'b0;
              done_r <= 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; a reset must leave loaded coefficients intact.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[~active][wptr] <= bus.D;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_r <= '0;
    end else if (!bus.CEN) begin
      for (int k = 0; k < NPORT; k++) begin
        q_r[k*DATA_W +: DATA_W] <= mem[active][bus.A[k*ADDR_W +: ADDR_W]];
      end
    end
  end

  assign bus.Q           = q_r;
  assign bus.ld_busy     = busy_r;
  assign bus.ld_done     = done_r;
  assign bus.swap_ack    = ack_r;
  assign bus.active_bank = active;
endmodule

// File: tb/tb_cmem_pingpong.sv
// Directed-sequence bench for cmem_pingpong with random coefficient data; expected read data
// comes from a per-bank array model updated with every accepted load word.
module tb_cmem_pingpong;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;
  localparam int NPORT  = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cmem_pingpong_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NPORT(NPORT)) bus ();

  cmem_pingpong #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NPORT(NPORT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: bank contents, which words are known, and which bank readers see.
  logic [DATA_W-1:0] mm [2][DEPTH];
  bit                mk [2][DEPTH];
  int                m_active;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] q_of(input int k);
    return bus.Q[k*DATA_W +: DATA_W];
  endfunction

  task automatic idle_inputs();
    bus.CEN      = 1'b1;
    bus.WEN      = 1'b1;
    bus.D        = '0;
    bus.ld_start = 1'b0;
    bus.swap_req = 1'b0;
  endtask

  task automatic set_all_addr(input int addr);
    for (int k = 0; k < NPORT; k++) bus.A[k*ADDR_W +: ADDR_W] = ADDR_W'(addr);
  endtask

  task automatic write_word(input int idx, input logic [DATA_W-1:0] v);
    bus.CEN = 1'b0;
    bus.WEN = 1'b0;
    bus.D   = v;
    tick();
    mm[1-m_active][idx] = v;
    mk[1-m_active][idx] = 1'b1;
    bus.CEN = 1'b1;
    bus.WEN = 1'b1;
  endtask

  task automatic start_load(input int last);
    bus.ld_start = 1'b1;
    bus.ld_last  = ADDR_W'(last);
    tick();
    bus.ld_start = 1'b0;
    check("ld_busy_start", 32'(bus.ld_busy), 32'd1);
  endtask

  task automatic load_words(input int last, input bit gaps, input bit randd, input logic [DATA_W-1:0] base);
    for (int i = 0; i <= last; i++) begin
      logic [DATA_W-1:0] v;
      v = randd ? DATA_W'($urandom) : DATA_W'(base * (i + 1));
      if (gaps) begin
        bus.CEN = 1'b0;
        bus.WEN = 1'b1;
        bus.D   = ~v;
        tick();
        check("gap_busy", 32'(bus.ld_busy), 32'd1);
        check("gap_done", 32'(bus.ld_done), 32'd0);
      end
      write_word(i, v);
      if (i < last) begin
        check("load_busy", 32'(bus.ld_busy), 32'd1);
        check("load_done_early", 32'(bus.ld_done), 32'd0);
      end else begin
        check("load_done_pulse", 32'(bus.ld_done), 32'd1);
        check("load_busy_end", 32'(bus.ld_busy), 32'd0);
      end
    end
    idle_inputs();
    tick();
    check("done_one_cycle", 32'(bus.ld_done), 32'd0);
    check("busy_idle", 32'(bus.ld_busy), 32'd0);
  endtask

  task automatic do_swap();
    bus.swap_req = 1'b1;
    tick();
    bus.swap_req = 1'b0;
    m_active = 1 - m_active;
    check("swap_ack", 32'(bus.swap_ack), 32'd1);
    check("swap_bank", 32'(bus.active_bank), 32'(m_active));
    tick();
    check("swap_ack_clear", 32'(bus.swap_ack), 32'd0);
  endtask

  // Reads addresses first..first+count-1 spread across all ports, checking known words.
  task automatic read_range(input int first, input int count);
    for (int b = 0; b < count; b += NPORT) begin
      for (int k = 0; k < NPORT; k++)
        bus.A[k*ADDR_W +: ADDR_W] = ADDR_W'(first + ((b + k) % count));
      bus.CEN = 1'b0;
      tick();
      bus.CEN = 1'b1;
      for (int k = 0; k < NPORT; k++) begin
        int a;
        a = first + ((b + k) % count);
        if (mk[m_active][a]) check($sformatf("read_p%0d_a%0d", k, a), 32'(q_of(k)), 32'(mm[m_active][a]));
      end
    end
  endtask

  initial begin
    m_active = 0;
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < DEPTH; a++) begin
        mk[b][a] = 1'b0;
        mm[b][a] = '0;
      end

    // 1: reset state, 4-word load, swap, multi-port read, CEN hold
    rst_n = 1'b0;
    idle_inputs();
    bus.A       = '0;
    bus.ld_last = '0;
    tick();
    tick();
    check("rst_busy", 32'(bus.ld_busy), 32'd0);
    check("rst_done", 32'(bus.ld_done), 32'd0);
    check("rst_ack", 32'(bus.swap_ack), 32'd0);
    check("rst_bank", 32'(bus.active_bank), 32'd0);
    for (int k = 0; k < NPORT; k++) check("rst_q", 32'(q_of(k)), 32'd0);
    rst_n = 1'b1;
    tick();

    start_load(3);
    load_words(3, 1'b0, 1'b0, 16'h1111);
    do_swap();
    read_range(0, 4);
    set_all_addr(200);
    tick();
    for (int k = 0; k < NPORT; k++) check("cen_hold", 32'(q_of(k)), 32'(mm[m_active][k % 4]));

    // 2: load with WEN gaps into the other bank
    start_load(5);
    load_words(5, 1'b1, 1'b1, '0);
    do_swap();
    read_range(0, 6);

    // 3: swap requested mid-load lands with the final write
    start_load(3);
    write_word(0, 16'hA000);
    write_word(1, 16'hA001);
    set_all_addr(0);
    bus.CEN      = 1'b0;
    bus.swap_req = 1'b1;
    tick();
    bus.swap_req = 1'b0;
    bus.CEN      = 1'b1;
    check("mid_no_ack", 32'(bus.swap_ack), 32'd0);
    check("mid_no_toggle", 32'(bus.active_bank), 32'(m_active));
    check("mid_old_taps", 32'(q_of(0)), 32'(mm[m_active][0]));
    tick();
    check("stall_no_toggle", 32'(bus.active_bank), 32'(m_active));
    check("stall_busy", 32'(bus.ld_busy), 32'd1);
    write_word(2, 16'hA002);
    check("pre_last_no_ack", 32'(bus.swap_ack), 32'd0);
    write_word(3, 16'hA003);
    m_active = 1 - m_active;
    check("done_with_ack_done", 32'(bus.ld_done), 32'd1);
    check("done_with_ack_ack", 32'(bus.swap_ack), 32'd1);
    check("done_with_ack_bank", 32'(bus.active_bank), 32'(m_active));
    tick();
    check("after_done_ack", 32'(bus.swap_ack), 32'd0);
    check("after_done_done", 32'(bus.ld_done), 32'd0);

    // 4: same address on all ports across the swap edge
    set_all_addr(2);
    bus.CEN      = 1'b0;
    bus.swap_req = 1'b1;
    tick();
    bus.swap_req = 1'b0;
    for (int k = 0; k < NPORT; k++) check("swap_edge_old", 32'(q_of(k)), 32'(mm[m_active][2]));
    m_active = 1 - m_active;
    check("swap_edge_ack", 32'(bus.swap_ack), 32'd1);
    tick();
    bus.CEN = 1'b1;
    for (int k = 0; k < NPORT; k++) check("swap_edge_new", 32'(q_of(k)), 32'(mm[m_active][2]));

    // 5: simultaneous start+swap, full-bank random load, ignored IDLE write, readback
    bus.ld_start = 1'b1;
    bus.swap_req = 1'b1;
    bus.ld_last  = ADDR_W'(DEPTH - 1);
    tick();
    bus.ld_start = 1'b0;
    bus.swap_req = 1'b0;
    m_active = 1 - m_active;
    check("simul_ack", 32'(bus.swap_ack), 32'd1);
    check("simul_bank", 32'(bus.active_bank), 32'(m_active));
    check("simul_busy", 32'(bus.ld_busy), 32'd1);
    load_words(DEPTH - 1, 1'b0, 1'b1, '0);
    bus.CEN = 1'b0;
    bus.WEN = 1'b0;
    bus.D   = 16'hDEAD;
    tick();
    idle_inputs();
    check("idle_write_busy", 32'(bus.ld_busy), 32'd0);
    do_swap();
    read_range(0, DEPTH);
    do_swap();
    read_range(0, 4);

    // 6: reset in the middle of a 64-word load, then a fresh load
    start_load(63);
    for (int i = 0; i < 10; i++) write_word(i, DATA_W'($urandom));
    rst_n = 1'b0;
    tick();
    m_active = 0;
    check("midrst_busy", 32'(bus.ld_busy), 32'd0);
    check("midrst_bank", 32'(bus.active_bank), 32'd0);
    check("midrst_done", 32'(bus.ld_done), 32'd0);
    for (int k = 0; k < NPORT; k++) check("midrst_q", 32'(q_of(k)), 32'd0);
    rst_n = 1'b1;
    tick();
    start_load(7);
    load_words(7, 1'b0, 1'b1, '0);
    do_swap();
    read_range(0, 8);
    do_swap();
    read_range(0, 16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
